// File: rtl/sr_ctrl.sv
// Status-register controller: merges ALU flags and software writes into SRSet,
// and keeps a small LIFO of saved status words for interrupt entry/return.
module sr_ctrl #(
  parameter int          DEPTH    = 4,
  parameter logic [7:0]  RESET_SR = 8'h00,
  localparam int         AW       = $clog2(DEPTH),
  localparam int         DW       = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [3:0]    alu_flags,
  input  logic [3:0]    flag_mask,
  input  logic          sr_wr,
  input  logic [7:0]    sr_wdata,
  input  logic          push,
  input  logic          pop,
  output logic [7:0]    SRSet,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty,
  output logic          ovf_err,
  output logic          unf_err
);

  logic [7:0]    sr_q, sr_d, base;
  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          stk_we;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [7:0]    stk_q [DEPTH];

  assign wr_idx = depth_q[AW-1:0];
  // Wraps correctly when depth_q == DEPTH (low bits are zero).
  assign rd_idx = depth_q[AW-1:0] - AW'(1);

  always_comb begin
    base = sr_q;
    for (int i = 0; i < 4; i++)
      if (alu_valid && flag_mask[i]) base[i] = alu_flags[i];
    if (sr_wr) base = sr_wdata;

    sr_d    = sr_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    stk_we  = 1'b0;
    if (pop) begin
      if (depth_q != '0) begin
        sr_d    = stk_q[rd_idx];
        depth_d = depth_q - DW'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (push) begin
      if (depth_q != DW'(DEPTH)) begin
        stk_we  = 1'b1;
        sr_d    = base & 8'hEF;
        depth_d = depth_q + DW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      sr_d = base;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q    <= RESET_SR;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage needs no reset: entries above depth are never read.
  always_ff @(posedge clk) begin
    if (stk_we) stk_q[wr_idx] <= sr_q;
  end

  assign SRSet   = sr_q;
  assign depth   = depth_q;
  assign full    = (depth_q == DW'(DEPTH));
  assign empty   = (depth_q == '0);
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

endmodule

// File: tb/tb_sr_ctrl.sv
// Self-checking bench for sr_ctrl: directed test-plan scenarios plus random
// traffic compared against a queue-based model of the status stack.
module tb_sr_ctrl;
  localparam int DEPTH = 4;

  logic       clk = 0, rst = 0;
  logic       alu_valid = 0, sr_wr = 0, push = 0, pop = 0;
  logic [3:0] alu_flags = 0, flag_mask = 0;
  logic [7:0] sr_wdata = 0;
  logic [7:0] SRSet;
  logic [2:0] depth;
  logic       full, empty, ovf_err, unf_err;

  int checks = 0, errors = 0;

  // reference model
  logic [7:0] m_sr;
  logic [7:0] m_stk[$];
  logic       m_ovf, m_unf;

  sr_ctrl #(.DEPTH(DEPTH), .RESET_SR(8'h00)) dut (
    .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_flags(alu_flags),
    .flag_mask(flag_mask), .sr_wr(sr_wr), .sr_wdata(sr_wdata), .push(push),
    .pop(pop), .SRSet(SRSet), .depth(depth), .full(full), .empty(empty),
    .ovf_err(ovf_err), .unf_err(unf_err));

  always #5 clk = ~clk;

  task automatic model_reset();
    m_sr = 8'h00; m_stk.delete(); m_ovf = 0; m_unf = 0;
  endtask

  // Apply one cycle of requests, advance the model, sample 1ns after the edge.
  task automatic cycle(input logic pu, input logic po, input logic wr,
                       input logic [7:0] wd, input logic av,
                       input logic [3:0] af, input logic [3:0] fm);
    logic [7:0] b;
    push = pu; pop = po; sr_wr = wr; sr_wdata = wd;
    alu_valid = av; alu_flags = af; flag_mask = fm;
    @(posedge clk);
    b = m_sr;
    for (int i = 0; i < 4; i++) if (av && fm[i]) b[i] = af[i];
    if (wr) b = wd;
    if (po) begin
      if (m_stk.size() > 0) m_sr = m_stk.pop_back();
      else m_unf = 1;
    end else if (pu) begin
      if (m_stk.size() < DEPTH) begin
        m_stk.push_back(m_sr);
        m_sr = b & 8'hEF;
      end else m_ovf = 1;
    end else m_sr = b;
    #1;
    push = 0; pop = 0; sr_wr = 0; alu_valid = 0;
  endtask

  task automatic wr_sr(input logic [7:0] v);
    cycle(0, 0, 1, v, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    wr_sr(8'h5A);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    checks++; if (depth !== 3'd2) begin errors++; $display("FAIL reset_pre_depth got %0d want 2", depth); end
    @(negedge clk); rst = 1; #1;
    model_reset();
    checks++; if (SRSet !== 8'h00) begin errors++; $display("FAIL reset_sr got %h want 00", SRSet); end
    checks++; if (depth !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_depth got d=%0d e=%b f=%b want 0 1 0", depth, empty, full); end
    checks++; if (ovf_err !== 1'b0 || unf_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b want 00", ovf_err, unf_err); end
    @(posedge clk); #1; rst = 0;
  endtask

  task automatic test_alu_merge();
    do_reset();
    wr_sr(8'h10);
    cycle(0, 0, 0, 0, 1, 4'b1011, 4'b0011);
    checks++; if (SRSet !== 8'h13) begin errors++; $display("FAIL alu_merge got %h want 13", SRSet); end
    cycle(0, 0, 1, 8'hA5, 1, 4'b1011, 4'b0011);
    checks++; if (SRSet !== 8'hA5) begin errors++; $display("FAIL alu_vs_wr got %h want a5", SRSet); end
    cycle(0, 0, 0, 0, 0, 4'b0000, 4'b1111);
    checks++; if (SRSet !== 8'hA5) begin errors++; $display("FAIL alu_invalid got %h want a5", SRSet); end
  endtask

  task automatic test_nested();
    do_reset();
    wr_sr(8'h1F);
    cycle(1, 0, 0, 0, 0, 0, 0);
    checks++; if (SRSet !== 8'h0F || depth !== 3'd1) begin errors++; $display("FAIL nest_push1 got %h d%0d want 0f d1", SRSet, depth); end
    wr_sr(8'h30);
    cycle(1, 0, 0, 0, 0, 0, 0);
    checks++; if (SRSet !== 8'h20 || depth !== 3'd2) begin errors++; $display("FAIL nest_push2 got %h d%0d want 20 d2", SRSet, depth); end
    cycle(0, 1, 0, 0, 0, 0, 0);
    checks++; if (SRSet !== 8'h30) begin errors++; $display("FAIL nest_pop1 got %h want 30", SRSet); end
    cycle(0, 1, 0, 0, 0, 0, 0);
    checks++; if (SRSet !== 8'h1F || empty !== 1'b1) begin errors++; $display("FAIL nest_pop2 got %h e=%b want 1f e=1", SRSet, empty); end
  endtask

  task automatic test_overflow();
    logic [7:0] want[4] = '{8'h01, 8'h01, 8'h01, 8'h11};
    do_reset();
    wr_sr(8'h11);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0, 0, 0);
    checks++; if (full !== 1'b1 || ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_pre got f=%b o=%b want 1 0", full, ovf_err); end
    cycle(1, 0, 1, 8'hFF, 0, 0, 0);
    checks++; if (ovf_err !== 1'b1 || depth !== 3'd4 || full !== 1'b1 || SRSet !== 8'h01) begin errors++; $display("FAIL ovf_push got o=%b d%0d f=%b sr=%h want 1 d4 1 01", ovf_err, depth, full, SRSet); end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, 0, 0, 0, 0);
      checks++; if (SRSet !== want[i]) begin errors++; $display("FAIL ovf_pop%0d got %h want %h", i, SRSet, want[i]); end
    end
    checks++; if (ovf_err !== 1'b1 || empty !== 1'b1) begin errors++; $display("FAIL ovf_sticky got o=%b e=%b want 1 1", ovf_err, empty); end
  endtask

  task automatic test_underflow();
    do_reset();
    wr_sr(8'h42);
    cycle(0, 1, 0, 0, 1, 4'hF, 4'hF);
    checks++; if (unf_err !== 1'b1 || SRSet !== 8'h42 || depth !== 3'd0) begin errors++; $display("FAIL unf got u=%b sr=%h d%0d want 1 42 0", unf_err, SRSet, depth); end
  endtask

  task automatic test_push_pop();
    do_reset();
    wr_sr(8'h17);
    cycle(1, 0, 0, 0, 0, 0, 0);
    wr_sr(8'h03);
    cycle(1, 1, 0, 0, 0, 0, 0);
    checks++; if (SRSet !== 8'h17 || depth !== 3'd0 || ovf_err !== 1'b0 || unf_err !== 1'b0) begin errors++; $display("FAIL push_pop got sr=%h d%0d o=%b u=%b want 17 0 0 0", SRSet, depth, ovf_err, unf_err); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0, 8'($urandom), 1'($urandom),
            4'($urandom), 4'($urandom));
      checks++;
      if (SRSet !== m_sr || depth !== 3'(m_stk.size()) || full !== (m_stk.size() == DEPTH) ||
          empty !== (m_stk.size() == 0) || ovf_err !== m_ovf || unf_err !== m_unf) begin
        errors++;
        $display("FAIL rand%0d got sr=%h d%0d f=%b e=%b o=%b u=%b want sr=%h d%0d o=%b u=%b",
                 n, SRSet, depth, full, empty, ovf_err, unf_err, m_sr, m_stk.size(), m_ovf, m_unf);
      end
      if ($urandom_range(0, 99) == 0) do_reset();
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_alu_merge();
    test_nested();
    test_overflow();
    test_underflow();
    test_push_pop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
